// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises to b[n] = b[n-1]^b[n-6]^b[n-7],
// then counts compared bits and errors, dropping lock when errors are excessive.
module prbs_checker #(
    parameter int CNT_W       = 32,
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_WIN    = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             din_valid,
    input  logic             din,
    output logic             locked,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_pulse,
    output logic             sat
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int WB_W  = $clog2(LOSS_WIN + 1);
    localparam int WE_W  = $clog2(LOSS_THRESH + 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_n;
    logic [6:0]       h, h_n;
    logic [2:0]       fill, fill_n;
    logic [RUN_W-1:0] good_run, good_run_n;
    logic [WB_W-1:0]  win_bits, win_bits_n;
    logic [WE_W-1:0]  win_errs, win_errs_n;
    logic [CNT_W-1:0] bit_count_n, err_count_n;
    logic             err_pulse_n, sat_n;
    logic             p;

    assign p      = h[0] ^ h[5] ^ h[6];
    assign locked = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            h         <= '0;
            fill      <= '0;
            good_run  <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            bit_count <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
            sat       <= 1'b0;
        end else begin
            state     <= state_n;
            h         <= h_n;
            fill      <= fill_n;
            good_run  <= good_run_n;
            win_bits  <= win_bits_n;
            win_errs  <= win_errs_n;
            bit_count <= bit_count_n;
            err_count <= err_count_n;
            err_pulse <= err_pulse_n;
            sat       <= sat_n;
        end
    end

    always_comb begin
        state_n     = state;
        h_n         = h;
        fill_n      = fill;
        good_run_n  = good_run;
        win_bits_n  = win_bits;
        win_errs_n  = win_errs;
        bit_count_n = bit_count;
        err_count_n = err_count;
        err_pulse_n = 1'b0;
        sat_n       = sat;

        if (din_valid) begin
            case (state)
                HUNT: begin
                    h_n = {h[5:0], din};
                    if (fill < 3'd7)
                        fill_n = fill + 3'd1;
                    else if ((din == p) && (h != '0))
                        good_run_n = good_run + RUN_W'(1);
                    else
                        good_run_n = '0;
                    if (good_run_n == RUN_W'(LOCK_CNT)) begin
                        state_n    = LOCKED;
                        win_bits_n = '0;
                        win_errs_n = '0;
                    end
                end
                LOCKED: begin
                    // Free-running prediction: a channel error is never fed back into h.
                    h_n         = {h[5:0], p};
                    win_bits_n  = win_bits + WB_W'(1);
                    bit_count_n = (bit_count == '1) ? bit_count : bit_count + CNT_W'(1);
                    if (din != p) begin
                        err_pulse_n = 1'b1;
                        win_errs_n  = win_errs + WE_W'(1);
                        err_count_n = (err_count == '1) ? err_count : err_count + CNT_W'(1);
                    end
                    if (win_errs_n == WE_W'(LOSS_THRESH)) begin
                        state_n    = HUNT;
                        h_n        = '0;
                        fill_n     = '0;
                        good_run_n = '0;
                    end else if (win_bits_n == WB_W'(LOSS_WIN)) begin
                        win_bits_n = '0;
                        win_errs_n = '0;
                    end
                end
                default: state_n = HUNT;
            endcase
        end

        sat_n = sat | (bit_count_n == '1) | (err_count_n == '1);

        // Clear beats a coincident valid bit for the counters only.
        if (clear) begin
            bit_count_n = '0;
            err_count_n = '0;
            sat_n       = 1'b0;
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker: a stream-level reference model checked every
// cycle against a full-width and a 4-bit-counter instance, plus literal scenario checks.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        locked_a, err_pulse_a, sat_a;
    logic [31:0] bit_count_a, err_count_a;
    logic        locked_b, err_pulse_b, sat_b;
    logic [3:0]  bit_count_b, err_count_b;

    always #5 clk = ~clk;

    prbs_checker #(.CNT_W(32), .LOCK_CNT(16), .LOSS_WIN(64), .LOSS_THRESH(8)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
        .locked(locked_a), .bit_count(bit_count_a), .err_count(err_count_a),
        .err_pulse(err_pulse_a), .sat(sat_a)
    );

    prbs_checker #(.CNT_W(4), .LOCK_CNT(16), .LOSS_WIN(64), .LOSS_THRESH(8)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
        .locked(locked_b), .bit_count(bit_count_b), .err_count(err_count_b),
        .err_pulse(err_pulse_b), .sat(sat_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of the bit stream as seen by the checker.
    int     mh[7];
    int     mfill, mrun, mlk, mwb, mwe, mpulse;
    longint mbc, mec;

    always @(posedge clk) begin
        int p, nz;
        if (reset) begin
            foreach (mh[k]) mh[k] = 0;
            mfill = 0; mrun = 0; mlk = 0; mwb = 0; mwe = 0; mpulse = 0;
            mbc = 0; mec = 0;
        end else begin
            mpulse = 0;
            if (din_valid) begin
                p = mh[0] ^ mh[5] ^ mh[6];
                if (mlk == 0) begin
                    nz = 0;
                    foreach (mh[k]) nz |= mh[k];
                    for (int k = 6; k > 0; k--) mh[k] = mh[k-1];
                    mh[0] = int'(din);
                    if (mfill < 7) mfill++;
                    else if ((int'(din) == p) && (nz != 0)) mrun++;
                    else mrun = 0;
                    if (mrun == 16) begin mlk = 1; mwb = 0; mwe = 0; end
                end else begin
                    for (int k = 6; k > 0; k--) mh[k] = mh[k-1];
                    mh[0] = p;
                    mbc++; mwb++;
                    if (int'(din) != p) begin mec++; mwe++; mpulse = 1; end
                    if (mwe == 8) begin
                        mlk = 0; mfill = 0; mrun = 0;
                        foreach (mh[k]) mh[k] = 0;
                    end else if (mwb == 64) begin
                        mwb = 0; mwe = 0;
                    end
                end
            end
            if (clear) begin mbc = 0; mec = 0; end
        end
    end

    bit chk_en = 1'b0;
    int pulse_cnt = 0;
    int lock_seen = 0;

    function automatic longint capv(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        longint mx_a, mx_b;
        if (chk_en) begin
            mx_a = 64'hFFFF_FFFF;
            mx_b = 15;
            check("locked_a", longint'(locked_a), mlk);
            check("bit_count_a", longint'(bit_count_a), capv(mbc, mx_a));
            check("err_count_a", longint'(err_count_a), capv(mec, mx_a));
            check("err_pulse_a", longint'(err_pulse_a), mpulse);
            check("sat_a", longint'(sat_a), longint'((mbc >= mx_a) || (mec >= mx_a)));
            check("locked_b", longint'(locked_b), mlk);
            check("bit_count_b", longint'(bit_count_b), capv(mbc, mx_b));
            check("err_count_b", longint'(err_count_b), capv(mec, mx_b));
            check("err_pulse_b", longint'(err_pulse_b), mpulse);
            check("sat_b", longint'(sat_b), longint'((mbc >= mx_b) || (mec >= mx_b)));
            pulse_cnt += int'(err_pulse_a);
            lock_seen |= int'(locked_a);
        end
    end

    // Transmit-side generator: shift left, feedback of bits 0,5,6 into LSB is the sent bit.
    logic [7:0] g;

    function automatic logic gen_bit();
        logic fb;
        fb = g[0] ^ g[5] ^ g[6];
        g  = {g[6:0], fb};
        return fb;
    endfunction

    task automatic cyc(input logic v, input logic d, input logic c);
        din_valid = v; din = d; clear = c;
        @(posedge clk);
        #1;
        din_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic vbit(input logic flip, input logic clr, input int pct);
        int gaps;
        gaps = 0;
        while ((int'($urandom_range(99)) >= pct) && (gaps < 20)) begin
            cyc(1'b0, 1'($urandom_range(1)), 1'b0);
            gaps++;
        end
        cyc(1'b1, gen_bit() ^ flip, clr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        g = 8'h0F;
    endtask

    // Feeds clean bits until lock (bounded); returns the valid-bit index of lock.
    task automatic acquire(input int pct, output int at);
        at = -1;
        for (int i = 1; i <= 100 && at < 0; i++) begin
            vbit(1'b0, 1'b0, pct);
            if (locked_a) at = i;
        end
    endtask

    initial begin
        int at;
        do_reset();
        chk_en = 1'b1;
        check("reset_locked", longint'(locked_a), 0);
        check("reset_bits", longint'(bit_count_a), 0);

        // Lock acquisition with a contiguous stream
        acquire(100, at);
        check("lock_at_23", at, 23);
        pulse_cnt = 0;
        for (int i = 0; i < 1000; i++) vbit(1'b0, 1'b0, 100);
        check("bits_1000", longint'(bit_count_a), 1000);
        check("errs_0", longint'(err_count_a), 0);
        check("no_pulses", pulse_cnt, 0);
        check("small_sat_bits", longint'(bit_count_b), 15);
        check("small_sat_flag", longint'(sat_b), 1);

        // Single error
        vbit(1'b1, 1'b0, 100);
        for (int i = 0; i < 200; i++) vbit(1'b0, 1'b0, 100);
        check("single_err", longint'(err_count_a), 1);
        check("single_pulse", pulse_cnt, 1);
        check("single_locked", longint'(locked_a), 1);

        // Loss on the 8th error in one window, then relock
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) vbit(1'b1, 1'b0, 100);
        check("loss_7_locked", longint'(locked_a), 1);
        vbit(1'b1, 1'b0, 100);
        check("loss_8_unlocked", longint'(locked_a), 0);
        check("loss_errs", longint'(err_count_a), 8);
        for (int i = 0; i < 22; i++) vbit(1'b0, 1'b0, 100);
        check("relock_22", longint'(locked_a), 0);
        vbit(1'b0, 1'b0, 100);
        check("relock_23", longint'(locked_a), 1);

        // Window reset: 7 errors, 64 clean, 7 errors stays locked
        for (int i = 0; i < 7; i++) vbit(1'b1, 1'b0, 100);
        for (int i = 0; i < 64; i++) vbit(1'b0, 1'b0, 100);
        for (int i = 0; i < 7; i++) vbit(1'b1, 1'b0, 100);
        check("window_locked", longint'(locked_a), 1);

        // Valid gaps, mid-operation reset, clear coinciding with a valid bit
        do_reset();
        acquire(50, at);
        check("gap_lock_at_23", at, 23);
        pulse_cnt = 0;
        for (int i = 0; i < 1000; i++) vbit(1'b0, 1'b0, 50);
        check("gap_bits_1000", longint'(bit_count_a), 1000);
        check("gap_errs_0", longint'(err_count_a), 0);
        vbit(1'b0, 1'b1, 50);
        check("clear_valid_bits", longint'(bit_count_a), 0);

        // All-zero guard
        do_reset();
        lock_seen = 0;
        for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0, 1'b0);
        check("zero_never_lock", lock_seen, 0);

        // Saturation of the 4-bit instance
        do_reset();
        acquire(100, at);
        for (int i = 0; i < 20; i++) vbit(1'b0, 1'b0, 100);
        check("sat4_bits", longint'(bit_count_b), 15);
        check("sat4_flag", longint'(sat_b), 1);
        check("sat32_bits", longint'(bit_count_a), 20);
        cyc(1'b0, 1'b0, 1'b1);
        check("sat4_clear_bits", longint'(bit_count_b), 0);
        check("sat4_clear_flag", longint'(sat_b), 0);

        // Random soak: sparse errors, bursts, clears and gaps
        for (int i = 0; i < 4000; i++) begin
            vbit(1'($urandom_range(39) == 0 || (i % 700 > 690)),
                 1'($urandom_range(199) == 0), 70);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
